// File: rtl/spi_slave_full_if.sv
// Signal bundle between the full-width SPI slave and the surrounding system.
// The slave modport is used by the slave RTL. The master modport is used by
// whatever drives the SPI pins and the load port.
interface spi_slave_full_if #(
    parameter int WIDTH = 392
);
    logic             load;
    logic [WIDTH-1:0] data_in;
    logic [WIDTH-1:0] data_out;
    logic             done;
    logic             buzy;
    logic             cs;
    logic             sclk;
    logic             mosi;
    logic             miso;

    modport slave (
        input  load,
        input  data_in,
        input  cs,
        input  sclk,
        input  mosi,
        output data_out,
        output done,
        output buzy,
        output miso
    );

    modport master (
        output load,
        output data_in,
        output cs,
        output sclk,
        output mosi,
        input  data_out,
        input  done,
        input  buzy,
        input  miso
    );
endinterface

// File: rtl/spi_slave_full.sv
// Full-width SPI slave, with sclk idling low.
// The slave shifts one WIDTH-bit frame in from mosi and out on miso, MSB first.
// Both registers move on each falling edge of sclk. A done pulse and a new
// data_out mark each complete frame.
// cs, sclk and mosi are oversampled through 2-flop synchronizers on the
// system clock.
module spi_slave_full #(
    parameter int WIDTH = 392
) (
    input  logic            clk,
    input  logic            reset,
    spi_slave_full_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        DRAIN  = 2'd2
    } state_t;

    localparam logic [8:0] LAST_BIT = 9'(WIDTH - 1);

    // Synchronizers and edge history
    logic       cs_s1_q, cs_s1_d, cs_s2_q, cs_s2_d;
    logic       sclk_s1_q, sclk_s1_d, sclk_s2_q, sclk_s2_d;
    logic       mosi_s1_q, mosi_s1_d, mosi_s2_q, mosi_s2_d;
    logic       sclk_prev_q, sclk_prev_d;
    logic       cs_prev_q, cs_prev_d;
    // fill_q marks when the synchronizer stages hold real pin samples rather
    // than their reset values. armed_q is set once a genuine cs-high has been
    // seen since reset. Without it, a cs line held low through reset would look
    // like a fresh cs fall, because the reset value of the synchronizer is 1.
    logic [1:0] fill_q, fill_d;
    logic       armed_q, armed_d;

    // Frame state
    state_t           state_q, state_d;
    logic [8:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0] tx_q, tx_d;
    // Only the most recent WIDTH-1 received bits are kept. The bit being
    // sampled completes the frame directly into data_out.
    logic [WIDTH-2:0] rx_q, rx_d;
    logic [WIDTH-1:0] data_out_q, data_out_d;
    logic             done_q, done_d;

    logic sclk_fall;
    logic cs_fall;

    assign sclk_fall = sclk_prev_q & ~sclk_s2_q;
    assign cs_fall   = armed_q & cs_prev_q & ~cs_s2_q;

    // Next values for the input synchronizers and edge-detect history
    always_comb begin
        cs_s1_d     = bus.cs;
        cs_s2_d     = cs_s1_q;
        sclk_s1_d   = bus.sclk;
        sclk_s2_d   = sclk_s1_q;
        mosi_s1_d   = bus.mosi;
        mosi_s2_d   = mosi_s1_q;
        sclk_prev_d = sclk_s2_q;
        cs_prev_d   = cs_s2_q;
        fill_d      = {fill_q[0], 1'b1};
        armed_d     = armed_q | (fill_q[1] & cs_s2_q);
    end

    // Register the synchronizers; reset parks them at cs high, sclk/mosi low
    always_ff @(posedge clk) begin
        if (reset) begin
            cs_s1_q     <= 1'b1;
            cs_s2_q     <= 1'b1;
            sclk_s1_q   <= 1'b0;
            sclk_s2_q   <= 1'b0;
            mosi_s1_q   <= 1'b0;
            mosi_s2_q   <= 1'b0;
            sclk_prev_q <= 1'b0;
            cs_prev_q   <= 1'b1;
            fill_q      <= 2'b00;
            armed_q     <= 1'b0;
        end else begin
            cs_s1_q     <= cs_s1_d;
            cs_s2_q     <= cs_s2_d;
            sclk_s1_q   <= sclk_s1_d;
            sclk_s2_q   <= sclk_s2_d;
            mosi_s1_q   <= mosi_s1_d;
            mosi_s2_q   <= mosi_s2_d;
            sclk_prev_q <= sclk_prev_d;
            cs_prev_q   <= cs_prev_d;
            fill_q      <= fill_d;
            armed_q     <= armed_d;
        end
    end

    // Frame FSM: state transitions, shift registers, counter and done pulse
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        tx_d       = tx_q;
        rx_d       = rx_q;
        data_out_d = data_out_q;
        done_d     = 1'b0;
        case (state_q)
            IDLE: begin
                // The load is applied even when a cs fall is seen in the same
                // cycle, so the frame starting now sends the new data.
                if (bus.load) begin
                    tx_d = bus.data_in;
                end
                if (cs_fall) begin
                    state_d = ACTIVE;
                    cnt_d   = '0;
                end
            end
            ACTIVE: begin
                if (cs_s2_q) begin
                    // Aborted frame: no done, data_out untouched.
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (sclk_fall) begin
                    rx_d  = {rx_q[WIDTH-3:0], mosi_s2_q};
                    tx_d  = {tx_q[WIDTH-2:0], 1'b0};
                    cnt_d = cnt_q + 9'd1;
                    if (cnt_q == LAST_BIT) begin
                        data_out_d = {rx_q, mosi_s2_q};
                        done_d     = 1'b1;
                        state_d    = DRAIN;
                    end
                end
            end
            DRAIN: begin
                // Surplus sclk falls are ignored until cs is released.
                if (cs_s2_q) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Register the frame state; reset clears everything
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            tx_q       <= '0;
            rx_q       <= '0;
            data_out_q <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            tx_q       <= tx_d;
            rx_q       <= rx_d;
            data_out_q <= data_out_d;
            done_q     <= done_d;
        end
    end

    assign bus.miso     = (state_q != IDLE) ? tx_q[WIDTH-1] : 1'b0;
    assign bus.buzy     = (state_q != IDLE);
    assign bus.done     = done_q;
    assign bus.data_out = data_out_q;

endmodule
